// File: rtl/input_conditioner_pkg.sv
// Shared types and constants for the input conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package input_cond_pkg;

  // Per-key debounce states.
  typedef enum logic [1:0] {
    REL        = 2'd0,
    PRESS_WAIT = 2'd1,
    PRESSED    = 2'd2,
    REL_WAIT   = 2'd3
  } db_state_t;

  // Stable cycles before a key level change is accepted (1 ms at 50 MHz).
  localparam int DB_CYCLES_DEFAULT = 50000;

  // Width of the debounce counter.
  localparam int DB_CNT_W = 16;

endpackage

// File: rtl/input_conditioner_if.sv
// Raw key/switch inputs and conditioned outputs of the input conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; levels and pulses only.
interface input_conditioner_if #(
  parameter int SW_WIDTH = 8
);
  logic                Run_n;
  logic                ClearLoad_n;
  logic [SW_WIDTH-1:0] SW;
  logic                Execute;
  logic                ClearA_LoadB;
  logic                Execute_rise;
  logic [SW_WIDTH-1:0] S;

  // Board side: drives the raw keys and switches, consumes conditioned values.
  modport master (
    output Run_n, ClearLoad_n, SW,
    input  Execute, ClearA_LoadB, Execute_rise, S
  );

  // Conditioner side.
  modport slave (
    input  Run_n, ClearLoad_n, SW,
    output Execute, ClearA_LoadB, Execute_rise, S
  );
endinterface

// File: rtl/input_conditioner_debounce_fsm.sv
// Debounces one synchronized, active-high key level.
// Latency: output follows a clean level change DB_CYCLES+1 edges after the level changes.
// Backpressure: none; glitches shorter than DB_CYCLES cycles are swallowed.
module debounce_fsm
  import input_cond_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Level,
  output logic Cond
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

  db_state_t           state;
  logic [DB_CNT_W-1:0] cnt;

  // State, counter and registered conditioned level; Cond is 1 in PRESSED/REL_WAIT.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= REL;
      cnt   <= '0;
      Cond  <= 1'b0;
    end else begin
      case (state)
        REL: begin
          if (Level) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!Level) begin
            state <= REL;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
            Cond  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!Level) begin
            state <= REL_WAIT;
            cnt   <= '0;
          end
        end
        REL_WAIT: begin
          if (Level) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= REL;
            cnt   <= '0;
            Cond  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= REL;
          cnt   <= '0;
          Cond  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes run/clear keys and operand switches; keys debounced when INPUT_CONDITIONER_DEBOUNCE_EN is defined.
// Latency: S 2 edges; keys 2+DB_CYCLES+1 edges (debounced) or 3 edges (macro undefined).
// Backpressure: none; Execute is held while the key is held, Execute_rise pulses once per press.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int SW_WIDTH  = 8
) (
  input logic                Clk,
  input logic                Reset,
  input_conditioner_if.slave io
);

  if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_db_range_bad
    $error("input_conditioner: DB_CYCLES out of range 2..65535");
  end

  logic [1:0]          run_sync;
  logic [1:0]          clr_sync;
  logic [SW_WIDTH-1:0] sw_s1;
  logic [SW_WIDTH-1:0] sw_s2;
  logic                run_lvl;
  logic                clr_lvl;
  logic                exec_q;
  logic                clr_q;
  logic                exec_d;

  // Two-flop synchronizers; keys reset to the released (high) level.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_sync <= 2'b11;
      clr_sync <= 2'b11;
      sw_s1    <= '0;
      sw_s2    <= '0;
    end else begin
      run_sync <= {run_sync[0], io.Run_n};
      clr_sync <= {clr_sync[0], io.ClearLoad_n};
      sw_s1    <= io.SW;
      sw_s2    <= sw_s1;
    end
  end

  assign run_lvl = ~run_sync[1];
  assign clr_lvl = ~clr_sync[1];

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
  debounce_fsm #(.DB_CYCLES(DB_CYCLES)) u_run_db (
    .Clk   (Clk),
    .Reset (Reset),
    .Level (run_lvl),
    .Cond  (exec_q)
  );

  debounce_fsm #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
    .Clk   (Clk),
    .Reset (Reset),
    .Level (clr_lvl),
    .Cond  (clr_q)
  );
`else
  // Without debounce the synchronized keys are simply registered once more.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      exec_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      exec_q <= run_lvl;
      clr_q  <= clr_lvl;
    end
  end
`endif

  // Previous Execute value, used to mark the first cycle Execute reads 1.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      exec_d <= 1'b0;
    end else begin
      exec_d <= exec_q;
    end
  end

  assign io.Execute      = exec_q;
  assign io.ClearA_LoadB = clr_q;
  assign io.Execute_rise = exec_q & ~exec_d;
  assign io.S            = sw_s2;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner against a run-length reference model.
// Latency: model predicts every output every cycle.
// Backpressure: n/a.
module tb_input_conditioner;

  localparam int DB = 4;
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  // Raw edge to conditioned output: 2 sync edges, then DB+1 stable samples or 1 register.
  localparam int LAT = DB_EN ? (DB + 3) : 3;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  input_conditioner_if #(.SW_WIDTH(8)) io ();

  input_conditioner #(.DB_CYCLES(DB), .SW_WIDTH(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .io    (io)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw samples delayed two edges, then a key output flips
  // once the level has disagreed with it for DB+1 consecutive samples.
  bit         m_run_q[$];
  bit         m_clr_q[$];
  logic [7:0] m_sw_q[$];
  bit         m_exec, m_exec_prev, m_clr;
  int         m_run_len, m_clr_len;
  logic [7:0] m_s;

  function automatic void model_reset();
    m_run_q = '{1'b1, 1'b1};
    m_clr_q = '{1'b1, 1'b1};
    m_sw_q  = '{8'h00};
    m_exec = 0; m_exec_prev = 0; m_clr = 0;
    m_run_len = 0; m_clr_len = 0;
    m_s = 8'h00;
  endfunction

  function automatic void cond_step(input bit lvl, inout bit out, inout int len);
    if (!DB_EN) begin
      out = lvl;
    end else if (lvl != out) begin
      len++;
      if (len == DB + 1) begin
        out = lvl;
        len = 0;
      end
    end else begin
      len = 0;
    end
  endfunction

  function automatic void model_edge();
    bit lr, lc;
    if (Reset) begin
      model_reset();
      return;
    end
    lr = ~m_run_q.pop_front();
    lc = ~m_clr_q.pop_front();
    m_s = m_sw_q.pop_front();
    m_run_q.push_back(io.Run_n);
    m_clr_q.push_back(io.ClearLoad_n);
    m_sw_q.push_back(io.SW);
    m_exec_prev = m_exec;
    cond_step(lr, m_exec, m_run_len);
    cond_step(lc, m_clr, m_clr_len);
  endfunction

  task automatic compare_all();
    check("execute", {31'b0, io.Execute}, {31'b0, m_exec});
    check("clear_load", {31'b0, io.ClearA_LoadB}, {31'b0, m_clr});
    check("execute_rise", {31'b0, io.Execute_rise}, {31'b0, m_exec & ~m_exec_prev});
    check("s", {24'b0, io.S}, {24'b0, m_s});
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    compare_all();
  endtask

  // Ticks n times; reports first tick where Execute==want and number of rise pulses.
  task automatic measure(input bit want, input int n, output int at, output int rises);
    at = -1;
    rises = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      rises += int'(io.Execute_rise);
      if (at < 0 && io.Execute == want) at = i;
    end
  endtask

  int at, at2, rises, hi;

  initial begin
    Reset = 1'b1;
    io.Run_n = 1'b1;
    io.ClearLoad_n = 1'b1;
    io.SW = 8'h00;
    model_reset();

    // Reset state held over several cycles.
    repeat (3) tick();
    check("reset_exec", {31'b0, io.Execute}, 32'd0);
    Reset = 1'b0;
    repeat (5) tick();

    // Clean press and release.
    io.Run_n = 1'b0;
    measure(1'b1, 20, at, rises);
    check("press_lat", at, LAT);
    check("press_rise_cnt", rises, 1);
    io.Run_n = 1'b1;
    measure(1'b0, 20, at, rises);
    check("release_lat", at, LAT);
    check("release_rise_cnt", rises, 0);

    // Glitch train: 3-cycle lows with 2-cycle gaps.
    hi = 0;
    rises = 0;
    for (int p = 0; p < 5; p++) begin
      io.Run_n = 1'b0;
      repeat (3) begin tick(); hi += int'(io.Execute); rises += int'(io.Execute_rise); end
      io.Run_n = 1'b1;
      repeat (2) begin tick(); hi += int'(io.Execute); rises += int'(io.Execute_rise); end
    end
    repeat (10) begin tick(); hi += int'(io.Execute); rises += int'(io.Execute_rise); end
    check("glitch_exec_hi", hi, DB_EN ? 0 : 15);
    check("glitch_rises", rises, DB_EN ? 0 : 5);

    // Single-cycle glitch.
    io.Run_n = 1'b0;
    tick();
    io.Run_n = 1'b1;
    measure(1'b1, 10, at, rises);
    check("glitch1_rises", rises, DB_EN ? 0 : 1);

    // Switch synchronizer latency.
    io.SW = 8'hA5;
    tick(); tick();
    check("sw_a5", {24'b0, io.S}, 32'hA5);
    io.SW = 8'h3C;
    tick();
    check("sw_1edge_old", {24'b0, io.S}, 32'hA5);
    tick();
    check("sw_3c", {24'b0, io.S}, 32'h3C);

    // Both keys pressed in the same cycle.
    io.Run_n = 1'b0;
    io.ClearLoad_n = 1'b0;
    at = -1; at2 = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (at < 0 && io.Execute) at = i;
      if (at2 < 0 && io.ClearA_LoadB) at2 = i;
    end
    check("both_exec_lat", at, LAT);
    check("both_clr_lat", at2, LAT);
    io.Run_n = 1'b1;
    io.ClearLoad_n = 1'b1;
    repeat (20) tick();

    // Reset while pressed clears outputs at once.
    io.Run_n = 1'b0;
    repeat (LAT + 2) tick();
    Reset = 1'b1;
    #1;
    model_reset();
    check("rst_pressed_exec", {31'b0, io.Execute}, 32'd0);
    check("rst_pressed_rise", {31'b0, io.Execute_rise}, 32'd0);
    repeat (2) tick();
    Reset = 1'b0;
    io.Run_n = 1'b1;
    repeat (10) tick();

    // Reset two cycles into PRESS_WAIT, key held across reset release.
    io.Run_n = 1'b0;
    repeat (5) tick();
    Reset = 1'b1;
    #1;
    model_reset();
    check("rst_mid_exec", {31'b0, io.Execute}, 32'd0);
    repeat (2) tick();
    Reset = 1'b0;
    measure(1'b1, 20, at, rises);
    check("rst_rel_lat", at, LAT);
    check("rst_rel_rises", rises, 1);
    io.Run_n = 1'b1;
    repeat (15) tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5, 0) == 0) io.Run_n = ~io.Run_n;
      if ($urandom_range(5, 0) == 0) io.ClearLoad_n = ~io.ClearLoad_n;
      if ($urandom_range(3, 0) == 0) io.SW = 8'($urandom);
      if (Reset) Reset = 1'b0;
      else if ($urandom_range(499, 0) == 0) Reset = 1'b1;
      tick();
    end
    Reset = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000, stable cycles required before a button level change is accepted (valid range 2..65535).
REQ-002 SHALL have parameter SW_WIDTH, default 8, width of the switch operand bus.
REQ-003 SHALL have port Clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Run_n  input  1  raw asynchronous run key, active-low.
REQ-006 SHALL have port ClearLoad_n  input  1  raw asynchronous clear/load key, active-low.
REQ-007 SHALL have port SW  input  SW_WIDTH  raw asynchronous operand switches.
REQ-008 SHALL have port Execute  output  1  conditioned run level, active-high, held while key held.
REQ-009 SHALL have port ClearA_LoadB  output  1  conditioned clear/load level, active-high.
REQ-010 SHALL have port Execute_rise  output  1  one-cycle pulse on Execute 0->1.
REQ-011 SHALL have port S  output  SW_WIDTH  synchronized switch value.

Function
REQ-012 Each key SHALL pass a two-flop synchronizer, then be inverted to active-high.
REQ-013 SW SHALL pass a two-flop synchronizer per bit; S = SW value two rising edges after SW stable; no debounce on SW.
REQ-014 Each key SHALL have an independent debounce FSM: states REL, PRESS_WAIT, PRESSED, REL_WAIT.
REQ-015 REL: synchronized level 1 -> PRESS_WAIT, counter cleared to 0; else stay.
REQ-016 PRESS_WAIT: level 1 -> counter+1; level 0 -> REL, counter cleared; counter reaching DB_CYCLES-1 with level 1 -> PRESSED.
REQ-017 PRESSED: level 0 -> REL_WAIT, counter cleared; else stay.
REQ-018 REL_WAIT: level 0 -> counter+1; level 1 -> PRESSED, counter cleared; counter reaching DB_CYCLES-1 with level 0 -> REL.
REQ-019 Conditioned output SHALL be 1 exactly in PRESSED and REL_WAIT, registered (no combinational path from inputs).
REQ-020 Press latency: conditioned output rises 2 + DB_CYCLES + 1 rising edges after a clean raw press; release symmetric.
REQ-021 Any glitch shorter than DB_CYCLES cycles SHALL produce no output change.
REQ-022 Counter SHALL be 16 bits, saturate-free (bounded by DB_CYCLES-1), never wrap.
REQ-023 Execute_rise SHALL be 1 for exactly one cycle, the cycle Execute first reads 1; never during reset.
REQ-024 Simultaneous press/release of both keys SHALL be handled independently; no priority or interlock.

Reset
REQ-025 Reset asserted SHALL immediately force: key sync flops to 1 (released), SW sync flops to 0, FSMs to REL, counters to 0, Execute=0, ClearA_LoadB=0, Execute_rise=0, S=0.
REQ-026 Reset mid-debounce SHALL discard progress; a key held across reset release is re-debounced from REL (full latency).

Configuration
REQ-027 Macro INPUT_CONDITIONER_DEBOUNCE_EN defined: debounce FSMs and counters compiled in as above.
REQ-028 Macro undefined: FSMs/counters omitted; Execute and ClearA_LoadB = inverted synchronized key, registered once (latency 3 edges); Execute_rise, sync and reset behaviour unchanged; DB_CYCLES ignored.

Structure
REQ-029 Shared package input_cond_pkg SHALL hold db_state_t enum (REL, PRESS_WAIT, PRESSED, REL_WAIT) and constant DB_CYCLES_DEFAULT = 50000.
REQ-030 Sub-module debounce_fsm (one key: sync'd level in, conditioned level out, DB_CYCLES parameter) SHALL be instantiated twice.
REQ-031 Outputs feed the multiplier control FSM directly: Execute held high keeps it in its finish state until release.

Verification (DB_CYCLES=4, macro defined unless stated)
REQ-032 Reset, Run_n=1 -> Execute=0, Execute_rise=0, S=0 throughout.
REQ-033 Run_n 1->0 held 20 cycles -> Execute rises on 7th edge after the input change, Execute_rise high exactly 1 cycle; Run_n->1 -> Execute falls 7 edges later.
REQ-034 Run_n pulsed low 3 cycles, 5 times with 2-cycle gaps -> Execute stays 0, Execute_rise never asserts.
REQ-035 SW=8'hA5 then 8'h3C -> S=8'hA5 after 2 edges, S=8'h3C 2 edges after change; both keys pressed same cycle -> both outputs rise same cycle.
REQ-036 Reset asserted 2 cycles into PRESS_WAIT with Run_n held low -> Execute=0 at once; after release, Execute rises 7 edges after reset deassert.
REQ-037 Macro undefined: Run_n 1->0 -> Execute=1 after 3 edges; 1-cycle glitch -> 1-cycle Execute pulse.
